// File: rtl/gate_vector_sequencer.sv
// Exhaustive stimulus sweep and golden-model checker for the NOT/AND/OR/XOR/MUX gate library.
// Optional macro STOP_ON_FAIL_EN: the first mismatch ends the run instead of completing the sweep.
module gate_vector_sequencer #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  output logic [WIDTH-1:0]   stim_a,
  output logic [WIDTH-1:0]   stim_b,
  output logic               stim_s,
  input  logic [WIDTH-1:0]   dut_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [2*WIDTH:0]   first_fail,
  output logic               fail_seen
);

  localparam int VW    = 2 * WIDTH + 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_NOT = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUX = 3'd4;

  function automatic logic [VW-1:0] last_index(input logic [2:0] o);
    logic [VW-1:0] r;
    r = '1;
    case (o)
      OP_NOT:                 r = {{(VW-WIDTH){1'b0}}, {WIDTH{1'b1}}};
      OP_AND, OP_OR, OP_XOR:  r = {1'b0, {(2*WIDTH){1'b1}}};
      default:                r = '1;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] golden(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b, input logic s);
    logic [WIDTH-1:0] r;
    r = '0;
    case (o)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MUX:  r = s ? b : a;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [VW-1:0]    v_q, v_d, v_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             s_q, s_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d, fs_q, fs_d;
  logic [ERR_W-1:0] err_q, err_d, err_inc;
  logic [VW-1:0]    ff_q, ff_d;
  logic             mismatch, finish;

  assign v_next   = v_q + VW'(1);
  assign mismatch = (dut_out != golden(op_q, a_q, b_q, s_q));
  assign err_inc  = (mismatch && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    op_d    = op_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fs_d    = fs_q;
    finish  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (op <= OP_MUX)) begin
          op_d    = op;
          v_d     = '0;
          cnt_d   = '0;
          a_d     = '0;
          b_d     = '0;
          s_d     = 1'b0;
          err_d   = '0;
          pass_d  = 1'b0;
          ff_d    = '0;
          fs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          err_d = err_inc;
          if (mismatch && !fs_q) begin
            ff_d = v_q;
            fs_d = 1'b1;
          end
`ifdef STOP_ON_FAIL_EN
          finish = mismatch || (v_q == last_index(op_q));
`else
          finish = (v_q == last_index(op_q));
`endif
          if (finish) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_inc == '0);
          end else begin
            // Fields unused by the latched op stay 0 even though v carries them.
            v_d = v_next;
            a_d = v_next[WIDTH-1:0];
            b_d = (op_q == OP_NOT) ? '0 : v_next[2*WIDTH-1:WIDTH];
            s_d = (op_q == OP_MUX) ? v_next[2*WIDTH] : 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      v_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fs_q    <= fs_d;
    end
  end

  assign stim_a     = a_q;
  assign stim_b     = b_q;
  assign stim_s     = s_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;
  assign fail_seen  = fs_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: a behavioural gate (with injectable faults) closes the loop,
// and a sweep-level reference model predicts run length, error count and first failing vector.
module tb_gate_vector_sequencer;
  localparam int W       = 4;
  localparam int SETTLE  = 2;
  localparam int ERR_W   = 7;
  localparam int MASK    = (1 << W) - 1;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [W-1:0] stim_a, stim_b, dut_out;
  logic stim_s, busy, done, pass, fail_seen;
  logic [ERR_W-1:0] err_cnt;
  logic [2*W:0] first_fail;

  int n_checks = 0;
  int n_errors = 0;
  int gate_op = 0, gate_mode = 0, gate_key = 0;

  always #5 clk = ~clk;

  gate_vector_sequencer #(.WIDTH(W), .SETTLE(SETTLE), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .stim_a(stim_a), .stim_b(stim_b), .stim_s(stim_s), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail(first_fail), .fail_seen(fail_seen)
  );

  function automatic int golden_ref(int o, int a, int b, int s);
    case (o)
      0: return (~a) & MASK;
      1: return a & b;
      2: return a | b;
      3: return a ^ b;
      4: return (s != 0) ? b : a;
      default: return 0;
    endcase
  endfunction

  // Gate under test: mode 0 correct, 1 bit0 stuck-at-0, 2 flip at vector key, 3 sparse flips, 4 inverted.
  function automatic int gate_model(int o, int a, int b, int s, int mode, int key);
    int idx, r;
    idx = (s << (2*W)) | (b << W) | a;
    r = golden_ref(o, a, b, s);
    case (mode)
      1: r = r & ~1;
      2: if (idx == key) r = r ^ 1;
      3: if (((idx * 37 + key) % 13) == 0) r = r ^ ((key % MASK) + 1);
      4: r = ~r;
      default: ;
    endcase
    return r & MASK;
  endfunction

  function automatic int last_of(int o);
    if (o == 0) return (1 << W) - 1;
    if (o <= 3) return (1 << (2*W)) - 1;
    return (1 << (2*W+1)) - 1;
  endfunction

  function automatic int pack_vec(int o, int idx);
    int a, b, s;
    a = idx & MASK;
    b = (o == 0) ? 0 : ((idx >> W) & MASK);
    s = (o == 4) ? ((idx >> (2*W)) & 1) : 0;
    return (s << (2*W)) | (b << W) | a;
  endfunction

  always_comb dut_out = W'(gate_model(gate_op, int'(stim_a), int'(stim_b), int'(stim_s), gate_mode, gate_key));

  task automatic model_run(input int o, input int mode, input int key, output int n_vec,
                           output int e_err, output int e_ff, output bit e_fs);
    int p, got, exp;
    n_vec = 0; e_err = 0; e_ff = 0; e_fs = 0;
    for (int v = 0; v <= last_of(o); v++) begin
      n_vec++;
      p = pack_vec(o, v);
      exp = golden_ref(o, p & MASK, (p >> W) & MASK, p >> (2*W));
      got = gate_model(o, p & MASK, (p >> W) & MASK, p >> (2*W), mode, key);
      if (got != exp) begin
        if (e_err < ERR_MAX) e_err++;
        if (!e_fs) begin e_fs = 1; e_ff = v; end
`ifdef STOP_ON_FAIL_EN
        break;
`endif
      end
    end
  endtask

  task automatic do_run(input int o, input int mode, input int key, input int repulse_t,
                        input int abort_t, input string name);
    int n_vec, e_err, e_ff, total, t, bad_t;
    bit e_fs, seen_done;
    logic [2*W:0] exp_stim, got_stim;
    logic [ERR_W-1:0] err_hold;
    model_run(o, mode, key, n_vec, e_err, e_ff, e_fs);
    total = n_vec * SETTLE;
    gate_op = o; gate_mode = mode; gate_key = key;
    @(negedge clk); op = 3'(o); start = 1'b1;
    @(negedge clk); start = 1'b0; op = 3'($urandom_range(0, 7));
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err_cnt !== '0 || fail_seen !== 1'b0) begin
      n_errors++;
      $display("FAIL %s/accept: busy=%b done=%b err=%0d fs=%b, required busy=1 done=0 err=0 fs=0",
               name, busy, done, err_cnt, fail_seen);
    end
    t = 0; bad_t = -1; seen_done = 0;
    while (!seen_done && t < total + 20) begin
      if (t == abort_t) return;
      start = (t == repulse_t);
      if (t == repulse_t) op = 3'($urandom_range(0, 4));
      @(negedge clk); t++;
      start = 1'b0;
      if (done === 1'b1) seen_done = 1;
      else if (t < total) begin
        exp_stim = (2*W+1)'(pack_vec(o, t / SETTLE));
        if (busy !== 1'b1 || {stim_s, stim_b, stim_a} !== exp_stim)
          if (bad_t < 0) bad_t = t;
      end
    end
    n_checks++;
    if (!seen_done || t != total) begin
      n_errors++;
      $display("FAIL %s/run_length: done_seen=%0d after %0d cycles, required %0d", name, seen_done, t, total);
    end
    n_checks++;
    if (bad_t >= 0) begin
      n_errors++;
      $display("FAIL %s/stim_seq: first wrong stimulus/busy at cycle %0d", name, bad_t);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s/busy_at_done: got %b required 0", name, busy);
    end
    n_checks++;
    if (err_cnt !== ERR_W'(e_err)) begin
      n_errors++;
      $display("FAIL %s/err_cnt: got %0d required %0d", name, err_cnt, e_err);
    end
    n_checks++;
    if (pass !== (e_err == 0)) begin
      n_errors++;
      $display("FAIL %s/pass: got %b required %b", name, pass, (e_err == 0));
    end
    n_checks++;
    if (fail_seen !== e_fs || (e_fs && first_fail !== (2*W+1)'(e_ff))) begin
      n_errors++;
      $display("FAIL %s/first_fail: got fs=%b ff=%0h required fs=%b ff=%0h", name, fail_seen, first_fail, e_fs, e_ff);
    end
    exp_stim = (2*W+1)'(pack_vec(o, n_vec - 1));
    got_stim = {stim_s, stim_b, stim_a};
    n_checks++;
    if (got_stim !== exp_stim) begin
      n_errors++;
      $display("FAIL %s/stim_final: got %0h required %0h", name, got_stim, exp_stim);
    end
    err_hold = err_cnt;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err_cnt !== err_hold || {stim_s, stim_b, stim_a} !== exp_stim) begin
      n_errors++;
      $display("FAIL %s/hold: done=%b busy=%b err=%0d stim=%0h, required 0 0 %0d %0h",
               name, done, busy, err_cnt, {stim_s, stim_b, stim_a}, err_hold, exp_stim);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, pass, fail_seen, err_cnt, first_fail, stim_s, stim_b, stim_a} !== '0) begin
      n_errors++;
      $display("FAIL reset/outputs: got %0h required 0",
               {busy, done, pass, fail_seen, err_cnt, first_fail, stim_s, stim_b, stim_a});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset/idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [2*W:0] got_stim;
    do_run(3, 3, 5, -1, 100 * SETTLE, "xor_abort");
    got_stim = {stim_s, stim_b, stim_a};
    n_checks++;
    if (got_stim !== (2*W+1)'(100)) begin
      n_errors++;
      $display("FAIL reset_mid/pre_vector: got %0h required %0h", got_stim, 100);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, pass, fail_seen, err_cnt, first_fail, stim_s, stim_b, stim_a} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid/outputs: got %0h required 0",
               {busy, done, pass, fail_seen, err_cnt, first_fail, stim_s, stim_b, stim_a});
    end
    rst_n = 1'b1;
    do_run(3, 0, 0, -1, -1, "xor_after_reset");
  endtask

  task automatic test_invalid_op();
    logic [ERR_W-1:0] err_hold;
    bit bad;
    err_hold = err_cnt;
    for (int o = 5; o <= 7; o++) begin
      bad = 0;
      @(negedge clk); op = 3'(o); start = 1'b1;
      @(negedge clk); start = 1'b0;
      if (busy !== 1'b0 || done !== 1'b0) bad = 1;
      repeat (3) begin
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0) bad = 1;
      end
      n_checks++;
      if (bad || err_cnt !== err_hold) begin
        n_errors++;
        $display("FAIL invalid_op%0d: busy=%b done=%b err=%0d, required idle with err=%0d",
                 o, busy, done, err_cnt, err_hold);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      do_run($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 600), -1, -1, "random");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    do_run(0, 0, 0, -1, -1, "not_clean");
    do_run(1, 1, 0, -1, -1, "and_stuck0");
    do_run(4, 0, 0, -1, -1, "mux_clean");
    do_run(1, 4, 0, -1, -1, "and_saturate");
    do_run(3, 2, 10, -1, -1, "xor_inject10");
    do_run(2, 3, 7, 7, -1, "or_restart_ignored");
    do_run(2, 0, 0, -1, -1, "back_to_back");
    test_invalid_op();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
